imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 145 ++++++++++++++
 tb/tb_imem_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into instruction words, writes them to
// instruction memory and releases core_reset once loaded. Define IMEM_LOADER_CHECKSUM_EN for the XOR checksum trailer.
module imem_loader #(
  parameter int                         addr_data_width = 32,
  parameter logic [addr_data_width-1:0] BASE_ADDR       = '0,
  parameter int                         DEPTH           = 256
) (
  input  logic                       clk1,
  input  logic                       reset1,
  input  logic                       start,
  input  logic [15:0]                len_words,
  input  logic                       byte_valid,
  input  logic [7:0]                 byte_data,
  output logic                       byte_ready,
  output logic                       imem_we,
  output logic [addr_data_width-1:0] imem_addr,
  output logic [addr_data_width-1:0] imem_wdata,
  output logic                       core_reset,
  output logic                       busy,
  output logic                       load_done,
  output logic                       err,
  output logic [2:0]                 dbg_state
);

  // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready;
  // byte_ready depends only on state, and the source holds byte_data stable while byte_valid is high.
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_len;
  logic [15:0] r_word_idx;
  logic [1:0]  r_byte_idx;
  logic [31:0] r_word;
  logic        r_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] r_csum;
  logic [31:0] r_csum_rx;
`endif

  logic w_accept;
  logic w_start_ok;
  logic w_len_zero;
  logic w_len_too_big;
  logic w_last_word;

  assign w_accept      = byte_valid && byte_ready;
  assign w_start_ok    = start && (r_state == IDLE || r_state == DONE);
  assign w_len_zero    = (len_words == 16'd0);
  assign w_len_too_big = int'({16'd0, len_words}) > DEPTH;
  assign w_last_word   = (r_word_idx == r_len - 16'd1);

  always_ff @(posedge clk1) begin
    if (reset1) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          if (w_len_zero || w_len_too_big) w_next_state = DONE;
          else                             w_next_state = RECV;
        end
      end
      RECV: begin
        if (w_accept && r_byte_idx == 2'd3) w_next_state = WRITE;
      end
      WRITE: begin
        if (!w_last_word) w_next_state = RECV;
`ifdef IMEM_LOADER_CHECKSUM_EN
        else              w_next_state = CHECK;
`else
        else              w_next_state = DONE;
`endif
      end
      CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (w_accept && r_byte_idx == 2'd3) w_next_state = DONE;
`else
        w_next_state = IDLE;
`endif
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (reset1) begin
      r_len      <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_word     <= '0;
      r_err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum     <= '0;
      r_csum_rx  <= '0;
`endif
    end else begin
      if (w_start_ok) begin
        r_err <= w_len_too_big;
        if (!w_len_zero && !w_len_too_big) begin
          r_len      <= len_words;
          r_word_idx <= '0;
          r_byte_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          r_csum     <= '0;
`endif
        end
      end
      if (w_accept && r_state == RECV) begin
        r_word[{r_byte_idx, 3'b000} +: 8] <= byte_data;
        r_byte_idx                        <= r_byte_idx + 2'd1;
      end
      if (r_state == WRITE) begin
        r_word_idx <= r_word_idx + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_csum     <= r_csum ^ r_word;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      // The fourth trailer byte is compared directly, without waiting for it to land in r_csum_rx.
      if (w_accept && r_state == CHECK) begin
        r_csum_rx[{r_byte_idx, 3'b000} +: 8] <= byte_data;
        r_byte_idx                           <= r_byte_idx + 2'd1;
        if (r_byte_idx == 2'd3)
          r_err <= ({byte_data, r_csum_rx[23:0]} != r_csum);
      end
`endif
    end
  end

  assign byte_ready = (r_state == RECV) || (r_state == CHECK);
  assign imem_we    = (r_state == WRITE);
  assign imem_addr  = (r_state == WRITE) ?
                      BASE_ADDR + addr_data_width'({r_word_idx, 2'b00}) : '0;
  assign imem_wdata = (r_state == WRITE) ? addr_data_width'(r_word) : '0;
  assign core_reset = (r_state != DONE);
  assign busy       = (r_state == RECV) || (r_state == WRITE) || (r_state == CHECK);
  assign load_done  = (r_state == DONE);
  assign err        = r_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven loads plus hand-written corner sequences; writes are checked
// against an expected {addr, data} queue filled when the stimulus is driven.
module tb_imem_loader;
  localparam int          AW   = 32;
  localparam int          W    = 64;
  localparam logic [31:0] BASE = 32'h0;

  logic          clk1 = 1'b0;
  logic          reset1;
  logic          start;
  logic [15:0]   len_words;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [AW-1:0] imem_wdata;
  logic          core_reset;
  logic          busy;
  logic          load_done;
  logic          err;
  logic [2:0]    dbg_state;

  imem_loader #(.addr_data_width(AW), .BASE_ADDR(BASE), .DEPTH(256)) dut (
    .clk1(clk1), .reset1(reset1), .start(start), .len_words(len_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_reset(core_reset), .busy(busy), .load_done(load_done), .err(err),
    .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clk1 = ~clk1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard
  int checks   = 0;
  int errors   = 0;
  int n_writes = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk1) begin
    if (imem_we) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", imem_addr, imem_wdata);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("imem_write", {imem_addr, imem_wdata}, e);
      end
    end
  end

  // Driver tasks
  task automatic start_load(input logic [15:0] len);
    start     = 1'b1;
    len_words = len;
    @(negedge clk1);
    start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk1);
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && t < 64) begin
      @(negedge clk1);
      t++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout: byte_ready 0 expected 1");
    end
    @(negedge clk1);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gap);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!load_done && t < 200) begin
      @(negedge clk1);
      t++;
    end
    check("load_done_reached", load_done, 1);
  endtask

  task automatic push_write(input int idx, input logic [31:0] w);
    exp_q.push_back({BASE + 32'(idx * 4), w});
  endtask

  typedef struct packed {
    logic [15:0] len;
    logic [3:0]  nwords;
    logic [63:0] bytes;
    logic [1:0]  gap;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[6];
  vec_t        v;
  logic [31:0] csum;
  logic [31:0] word;

  initial begin
    reset1 = 1'b1; start = 1'b0; len_words = '0; byte_valid = 1'b0; byte_data = '0;
    vecs[0] = '{len: 16'd0,   nwords: 4'd0, bytes: 64'h0,                 gap: 2'd0, exp_err: 1'b0};
    vecs[1] = '{len: 16'd2,   nwords: 4'd2, bytes: 64'hFFF00593_00A00513, gap: 2'd0, exp_err: 1'b0};
    vecs[2] = '{len: 16'd1,   nwords: 4'd1, bytes: 64'h00000000_00B500B3, gap: 2'd1, exp_err: 1'b0};
    vecs[3] = '{len: 16'd257, nwords: 4'd0, bytes: 64'h0,                 gap: 2'd0, exp_err: 1'b1};
    vecs[4] = '{len: 16'd2,   nwords: 4'd2, bytes: {$urandom(), $urandom()},
                gap: 2'($urandom_range(0, 2)), exp_err: 1'b0};
    vecs[5] = '{len: 16'd1,   nwords: 4'd1, bytes: 64'h00000000_12345678, gap: 2'd0, exp_err: 1'b0};

    repeat (3) @(negedge clk1);
    reset1 = 1'b0;
    check("rst_imem_we",    imem_we, 0);
    check("rst_imem_addr",  imem_addr, 0);
    check("rst_imem_wdata", imem_wdata, 0);
    check("rst_byte_ready", byte_ready, 0);
    check("rst_busy",       busy, 0);
    check("rst_load_done",  load_done, 0);
    check("rst_err",        err, 0);
    check("rst_core_reset", core_reset, 1);

    // Table-driven loads
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      n_writes = 0;
      csum = '0;
      for (int k = 0; k < int'(v.nwords); k++) begin
        word = v.bytes[32*k +: 32];
        push_write(k, word);
        csum = csum ^ word;
      end
      start_load(v.len);
      if (v.nwords == 0) begin
        check("short_load_done", load_done, 1);
        check("short_busy", busy, 0);
        check("short_err", err, v.exp_err);
      end else begin
        check("start_busy", busy, 1);
        check("start_core_reset", core_reset, 1);
        check("start_err_clear", err, 0);
        for (int b = 0; b < 4 * int'(v.nwords); b++) send_byte(v.bytes[8*b +: 8], int'(v.gap));
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(csum, 0);
`endif
        wait_done();
      end
      @(negedge clk1);
      check("vec_err", err, v.exp_err);
      check("vec_core_reset", core_reset, 0);
      check("vec_busy", busy, 0);
      check("vec_nwrites", n_writes, 64'(v.nwords));
      check("vec_queue_empty", exp_q.size(), 0);
    end

    // Write strobe lands exactly one cycle after the fourth accepted byte
    n_writes = 0;
    push_write(0, 32'h00B500B3);
    start_load(16'd1);
    send_byte(8'hB3, 1);
    send_byte(8'h00, 1);
    send_byte(8'hB5, 1);
    check("we_before_4th", imem_we, 0);
    send_byte(8'h00, 1);
    check("we_after_4th", imem_we, 1);
    @(negedge clk1);
    check("we_single_cycle", imem_we, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(32'h00B500B3, 0);
`endif
    wait_done();
    check("timing_nwrites", n_writes, 1);

    // Reset mid-load discards the partial word
    n_writes = 0;
    start_load(16'd1);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    reset1 = 1'b1;
    @(negedge clk1);
    reset1 = 1'b0;
    check("midrst_state", dbg_state, 0);
    check("midrst_busy", busy, 0);
    check("midrst_byte_ready", byte_ready, 0);
    check("midrst_core_reset", core_reset, 1);
    @(negedge clk1);
    check("midrst_no_write", imem_we, 0);
    push_write(0, 32'h00341237);
    start_load(16'd1);
    send_word(32'h00341237, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(32'h00341237, 0);
`endif
    wait_done();
    check("midrst_nwrites", n_writes, 1);

    // Reset wins over start and byte handshakes in the same cycle
    reset1 = 1'b1; start = 1'b1; len_words = 16'd1; byte_valid = 1'b1;
    @(negedge clk1);
    reset1 = 1'b0; start = 1'b0; byte_valid = 1'b0;
    check("rstprio_state", dbg_state, 0);
    check("rstprio_busy", busy, 0);
    check("rstprio_load_done", load_done, 0);

    // start during RECV is ignored
    n_writes = 0;
    push_write(0, 32'h11223344);
    push_write(1, 32'h55667788);
    start_load(16'd2);
    send_word(32'h11223344, 0);
    send_byte(8'h88, 0);
    send_byte(8'h77, 0);
    start_load(16'd1);
    check("ign_start_busy", busy, 1);
    send_byte(8'h66, 0);
    send_byte(8'h55, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(32'h11223344 ^ 32'h55667788, 0);
`endif
    wait_done();
    check("ign_start_nwrites", n_writes, 2);
    check("ign_start_queue", exp_q.size(), 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum trailer: matching and mismatching
    for (int j = 0; j < 2; j++) begin
      push_write(0, 32'h00000013);
      push_write(1, 32'h00A00513);
      start_load(16'd2);
      send_word(32'h00000013, 0);
      send_word(32'h00A00513, 0);
      send_word((j == 0) ? 32'h00A00500 : 32'h00000000, 0);
      wait_done();
      check("csum_err", err, (j == 0) ? 0 : 1);
    end
`endif

    repeat (3) @(negedge clk1);
    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
